// File: rtl/ysyx_22051468_issue_scoreboard_pkg.sv
// Shared constants, FSM state encoding and register one-hot helper for the issue scoreboard.
package ysyx_22051468_issue_scoreboard_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned AW    = $clog2(NREG);
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ScbRun   = 2'd0,
        ScbStall = 2'd1,
        ScbFlush = 2'd2
    } scb_state_e;

    // x0 maps to an all-zero mask so it can never be marked busy or hazard.
    function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] idx);
        logic [NREG-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        oh[0]   = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/ysyx_22051468_issue_scoreboard_if.sv
// Decode/writeback/flush bundle between the pipeline (master) and the scoreboard (slave).
interface ysyx_22051468_issue_scoreboard_if;
    import ysyx_22051468_issue_scoreboard_pkg::*;

    logic             issue_valid;
    logic             issue_ready;
    logic             rd_need;
    logic             rs1_need;
    logic             rs2_need;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic             flush;
    logic [NREG-1:0]  busy_vec;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output issue_valid, rd_need, rs1_need, rs2_need, rd_addr, rs1_addr, rs2_addr,
        output wb_valid, wb_rd, flush,
        input  issue_ready, busy_vec, stall_cnt
    );

    modport slave (
        input  issue_valid, rd_need, rs1_need, rs2_need, rd_addr, rs1_addr, rs2_addr,
        input  wb_valid, wb_rd, flush,
        output issue_ready, busy_vec, stall_cnt
    );

endinterface

// File: rtl/ysyx_22051468_scb_hazard.sv
// Combinational RAW/WAW detection against the busy vector.
// YSYX_22051468_SCB_BYPASS_EN: a same-cycle writeback masks its register's busy bit.
module ysyx_22051468_scb_hazard
    import ysyx_22051468_issue_scoreboard_pkg::*;
(
    input  logic [NREG-1:0] busy_i,
    input  logic            rd_need_i,
    input  logic            rs1_need_i,
    input  logic            rs2_need_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_rd_i,
    output logic            raw_o,
    output logic            waw_o
);

    logic [NREG-1:0] busy_eff;

`ifdef YSYX_22051468_SCB_BYPASS_EN
    always_comb begin
        busy_eff = busy_i;
        if (wb_valid_i) begin
            busy_eff = busy_i & ~reg_onehot(wb_rd_i);
        end
        busy_eff[0] = 1'b0;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid_i, wb_rd_i};

    always_comb begin
        busy_eff    = busy_i;
        busy_eff[0] = 1'b0;
    end
`endif

    always_comb begin
        raw_o = (rs1_need_i & busy_eff[rs1_addr_i]) | (rs2_need_i & busy_eff[rs2_addr_i]);
        waw_o = rd_need_i & busy_eff[rd_addr_i];
    end

endmodule

// File: rtl/ysyx_22051468_issue_scoreboard.sv
// Issue scoreboard: busy register, RUN/STALL/FLUSH interlock FSM and saturating stall counter.
// Optional writeback bypass into hazard detection via YSYX_22051468_SCB_BYPASS_EN.
module ysyx_22051468_issue_scoreboard
    import ysyx_22051468_issue_scoreboard_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    ysyx_22051468_issue_scoreboard_if.slave    sb
);

    scb_state_e       state_q, state_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw, waw, hazard, ready, fire;

    ysyx_22051468_scb_hazard u_hazard (
        .busy_i     (busy_q),
        .rd_need_i  (sb.rd_need),
        .rs1_need_i (sb.rs1_need),
        .rs2_need_i (sb.rs2_need),
        .rd_addr_i  (sb.rd_addr),
        .rs1_addr_i (sb.rs1_addr),
        .rs2_addr_i (sb.rs2_addr),
        .wb_valid_i (sb.wb_valid),
        .wb_rd_i    (sb.wb_rd),
        .raw_o      (raw),
        .waw_o      (waw)
    );

    // A flush request blocks issue in its own cycle; the FLUSH state blocks the following one.
    always_comb begin
        hazard = raw | waw;
        ready  = ~rst & ~sb.flush & (state_q != ScbFlush) & ~hazard;
        fire   = sb.issue_valid & ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ScbRun:   if (sb.issue_valid & hazard) state_d = ScbStall;
            ScbStall: if (fire | ~sb.issue_valid) state_d = ScbRun;
            ScbFlush: state_d = ScbRun;
            default:  state_d = ScbRun;
        endcase
        if (sb.flush) state_d = ScbFlush;
    end

    // Clear before set so a same-index retire and new issue leave the register busy.
    always_comb begin
        busy_d = busy_q;
        if (sb.flush) begin
            busy_d = '0;
        end else begin
            if (sb.wb_valid) busy_d = busy_d & ~reg_onehot(sb.wb_rd);
            if (fire & sb.rd_need) busy_d = busy_d | reg_onehot(sb.rd_addr);
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sb.issue_valid & ~ready & (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ScbRun;
            busy_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sb.issue_ready = ready;
    assign sb.busy_vec    = busy_q;
    assign sb.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_22051468_issue_scoreboard.sv
// Directed table-driven bench for the issue scoreboard plus multi-cycle corner sequences.
module tb_ysyx_22051468_issue_scoreboard;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_22051468_issue_scoreboard_if sb_if ();

    ysyx_22051468_issue_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rd_n;
        logic        rs1_n;
        logic        rs2_n;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wb_v;
        logic [4:0]  wb_rd;
        logic        flush;
        logic        exp_ready;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic v, input logic rdn, input logic r1n, input logic r2n,
                                input int rd, input int rs1, input int rs2, input logic wbv,
                                input int wbrd, input logic fl, input logic er,
                                input logic [31:0] eb);
        vec_t t;
        t.valid = v;  t.rd_n = rdn;  t.rs1_n = r1n;  t.rs2_n = r2n;
        t.rd = 5'(rd);  t.rs1 = 5'(rs1);  t.rs2 = 5'(rs2);
        t.wb_v = wbv;  t.wb_rd = 5'(wbrd);  t.flush = fl;
        t.exp_ready = er;  t.exp_busy = eb;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        sb_if.issue_valid = t.valid;
        sb_if.rd_need     = t.rd_n;
        sb_if.rs1_need    = t.rs1_n;
        sb_if.rs2_need    = t.rs2_n;
        sb_if.rd_addr     = t.rd;
        sb_if.rs1_addr    = t.rs1;
        sb_if.rs2_addr    = t.rs2;
        sb_if.wb_valid    = t.wb_v;
        sb_if.wb_rd       = t.wb_rd;
        sb_if.flush       = t.flush;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b3, b5, b7, b9;
    logic        exp_byp_ready;
    int          exp_cnt;

    initial begin
        checks = 0;
        errors = 0;
        b3 = 32'h1 << 3;  b5 = 32'h1 << 5;  b7 = 32'h1 << 7;  b9 = 32'h1 << 9;

        //            v rdn r1n r2n rd rs1 rs2 wbv wbrd fl  rdy busy
        vecs[0]  = mk(1, 1, 0, 0,  5,  0,  0, 0, 0,  0, 1, 0);
        vecs[1]  = mk(1, 0, 1, 0,  0,  5,  0, 0, 0,  0, 0, b5);
        vecs[2]  = mk(1, 0, 0, 1,  0,  0,  5, 0, 0,  0, 0, b5);
        vecs[3]  = mk(0, 0, 0, 0,  0,  0,  0, 1, 5,  0, 1, b5);
        vecs[4]  = mk(1, 1, 1, 0,  0,  0,  0, 0, 0,  0, 1, 0);
        vecs[5]  = mk(1, 1, 1, 1,  0,  0,  0, 0, 0,  0, 1, 0);
        vecs[6]  = mk(1, 1, 0, 0,  9,  0,  0, 1, 9,  0, 1, 0);
        vecs[7]  = mk(1, 1, 0, 0,  9,  0,  0, 0, 0,  0, 0, b9);
        vecs[8]  = mk(0, 0, 0, 0,  0,  0,  0, 1, 9,  0, 1, b9);
        vecs[9]  = mk(1, 1, 1, 1,  3,  3,  7, 0, 0,  0, 1, 0);
        vecs[10] = mk(1, 1, 0, 0,  7,  0,  0, 0, 0,  0, 1, b3);
        vecs[11] = mk(1, 1, 0, 0, 12,  0,  0, 1, 3,  1, 0, b3 | b7);
        vecs[12] = mk(1, 1, 0, 0, 12,  0,  0, 0, 0,  0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0,  0,  0,  0, 1, 3,  0, 1, 0);
        vecs[14] = mk(1, 0, 1, 1,  0, 12,  3, 0, 0,  0, 1, 0);
        vecs[15] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0, 1, 0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #3;
        chk("reset ready", 32'(sb_if.issue_ready), 32'h0);
        chk("reset busy", sb_if.busy_vec, 32'h0);
        chk("reset cnt", sb_if.stall_cnt, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        chk("post-reset ready", 32'(sb_if.issue_ready), 32'h1);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d ready", i), 32'(sb_if.issue_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d busy", i), sb_if.busy_vec, vecs[i].exp_busy);
            next_cycle();
        end
        chk("table stall_cnt", sb_if.stall_cnt, 32'd5);

        // RAW on x5 resolved by writeback, with and without bypass
`ifdef YSYX_22051468_SCB_BYPASS_EN
        exp_byp_ready = 1'b1;
        exp_cnt = 6;
`else
        exp_byp_ready = 1'b0;
        exp_cnt = 7;
`endif
        drive(mk(1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("raw issue producer", 32'(sb_if.issue_ready), 32'h1);
        next_cycle();
        drive(mk(1, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0));
        #2;
        chk("raw stall ready", 32'(sb_if.issue_ready), 32'h0);
        chk("raw stall busy", sb_if.busy_vec, b5);
        next_cycle();
        drive(mk(1, 0, 1, 0, 0, 5, 0, 1, 5, 0, 0, 0));
        #2;
        chk("raw wb-cycle ready", 32'(sb_if.issue_ready), 32'(exp_byp_ready));
        next_cycle();
        drive(mk(1, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0));
        #2;
        chk("raw after-wb ready", 32'(sb_if.issue_ready), 32'h1);
        chk("raw after-wb busy", sb_if.busy_vec, 32'h0);
        next_cycle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("raw stall_cnt", sb_if.stall_cnt, 32'(exp_cnt));

        // Ten-cycle stall from a fresh reset, then asynchronous reset mid-stall
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(mk(1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
        #2;
        chk("stall10 producer ready", 32'(sb_if.issue_ready), 32'h1);
        chk("stall10 cnt start", sb_if.stall_cnt, 32'h0);
        next_cycle();
        drive(mk(1, 0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 10; c++) next_cycle();
        chk("stall10 cnt", sb_if.stall_cnt, 32'd10);
        chk("stall10 ready", 32'(sb_if.issue_ready), 32'h0);
        chk("stall10 busy", sb_if.busy_vec, 32'h1 << 4);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ready", 32'(sb_if.issue_ready), 32'h0);
        chk("async rst busy", sb_if.busy_vec, 32'h0);
        chk("async rst cnt", sb_if.stall_cnt, 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("release ready", 32'(sb_if.issue_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
